// File: rtl/op_seq_pkg.sv
// Shared definitions for the operation sequencer: opcodes, FSM states,
// operation-word / size field positions and the run-length rule.
package op_seq_pkg;

  localparam logic [3:0] OP_IDLE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_WRITE = 4'd2;
  localparam logic [3:0] OP_READ  = 4'd3;

  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned OPC_MSB  = 3;
  localparam int unsigned SZ_C_LSB = 0;
  localparam int unsigned SZ_C_MSB = 5;
  localparam int unsigned SZ_L_LSB = 6;
  localparam int unsigned SZ_L_MSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_FLUSH
  } state_t;

  function automatic logic opc_legal(input logic [3:0] opc);
    return (opc == OP_MULT) || (opc == OP_WRITE) || (opc == OP_READ);
  endfunction

  // Cycles an operation occupies the controller, from C = size[5:0]+1, L = size[8:6]+1.
  function automatic logic [15:0] run_len(input logic [3:0]  opc,
                                          input logic [8:0]  sz,
                                          input logic [15:0] drain);
    logic [15:0] c;
    logic [15:0] l;
    c = 16'(sz[SZ_C_MSB:SZ_C_LSB]) + 16'd1;
    l = 16'(sz[SZ_L_MSB:SZ_L_LSB]) + 16'd1;
    if (opc == OP_MULT) return (l * l * c) + drain;
    else                return (l * c) << 3;
  endfunction

endpackage

// File: rtl/op_fifo.sv
// DEPTH x WIDTH synchronous command FIFO: show-ahead head, written data visible
// the cycle after the push, synchronous clear that overrides push and pop.
module op_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty && !clear;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok) && !clear;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/op_sequencer.sv
// Feeds operation words from a command FIFO to the matrix controller, one run at a time.
// Optional perf counters (perf_busy_cycles, perf_ops) when OP_SEQUENCER_PERF_EN is defined.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DRAIN = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic [8:0]  size,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] ctrl_operation,
  output logic [31:0] ctrl_in_data,
  output logic        ctrl_enable,
  output logic        ctrl_reset,
  output logic        busy,
  output logic        done,
  output logic        illegal
`ifdef OP_SEQUENCER_PERF_EN
  ,
  output logic [31:0] perf_busy_cycles,
  output logic [31:0] perf_ops
`endif
);

  localparam logic [15:0] DRAIN_W = 16'(DRAIN);

  state_t      state;
  logic [15:0] count;
  logic        live;
  logic [31:0] head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        is_run;
  logic        run_en;
  logic [3:0]  opc;
  logic [3:0]  head_opc;

  // ctrl_operation holds the active word for the whole RUN, so it doubles as the opcode store.
  assign opc      = ctrl_operation[OPC_MSB:OPC_LSB];
  assign head_opc = head[OPC_MSB:OPC_LSB];
  assign is_run   = (state == ST_RUN);

  assign pop  = !flush && !fifo_empty && ((state == ST_IDLE) || (state == ST_GAP));
  assign push = cmd_valid && cmd_ready && !flush;

  assign cmd_ready = !fifo_full || pop;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  always_comb begin
    run_en = 1'b0;
    if (opc == OP_MULT)  run_en = 1'b1;
    if (opc == OP_WRITE) run_en = wr_valid;
    if (opc == OP_READ)  run_en = rd_ready;
  end

  assign wr_ready     = is_run && (opc == OP_WRITE);
  assign rd_valid     = is_run && (opc == OP_READ);
  assign ctrl_in_data = wr_ready ? wr_data : '0;
  // live keeps enable low while reset is held and in the first cycle after it.
  assign ctrl_enable  = live && (is_run ? run_en : 1'b1);

  op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (cmd_data),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      count          <= '0;
      live           <= 1'b0;
      ctrl_operation <= '0;
      ctrl_reset     <= 1'b0;
      done           <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      live       <= 1'b1;
      ctrl_reset <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      if (flush) begin
        state          <= ST_FLUSH;
        ctrl_operation <= '0;
        ctrl_reset     <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE, ST_GAP: begin
            ctrl_operation <= '0;
            state          <= ST_IDLE;
            if (pop) begin
              if (opc_legal(head_opc)) begin
                state          <= ST_RUN;
                ctrl_operation <= head;
                count          <= run_len(head_opc, size, DRAIN_W) - 16'd1;
              end else begin
                illegal <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (run_en) begin
              if (count == '0) begin
                state          <= ST_GAP;
                ctrl_operation <= '0;
                done           <= 1'b1;
              end else begin
                count <= count - 16'd1;
              end
            end
          end
          ST_FLUSH: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef OP_SEQUENCER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_cycles <= '0;
      perf_ops         <= '0;
    end else if (flush) begin
      perf_busy_cycles <= '0;
      perf_ops         <= '0;
    end else begin
      if (is_run && (perf_busy_cycles != '1))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (is_run && run_en && (count == '0) && (perf_ops != '1))
        perf_ops <= perf_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: randomized runs checked against a
// cycle-timeline model derived from the opcode run-length rules.
module tb_op_sequencer;

  localparam int DRAIN = 24;

  logic        clk = 1'b0;
  logic        reset, flush, cmd_valid, cmd_ready;
  logic [31:0] cmd_data;
  logic [8:0]  size;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [31:0] wr_data, ctrl_operation, ctrl_in_data;
  logic        ctrl_enable, ctrl_reset, busy, done, illegal;
`ifdef OP_SEQUENCER_PERF_EN
  logic [31:0] perf_busy_cycles, perf_ops;
`endif

  int total = 0;
  int bad   = 0;
  int ops_model  = 0;
  int busy_model = 0;

  always #5 clk = ~clk;

  op_sequencer #(.DEPTH(8), .DRAIN(DRAIN)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .size           (size),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .ctrl_operation (ctrl_operation),
    .ctrl_in_data   (ctrl_in_data),
    .ctrl_enable    (ctrl_enable),
    .ctrl_reset     (ctrl_reset),
    .busy           (busy),
    .done           (done),
    .illegal        (illegal)
`ifdef OP_SEQUENCER_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_ops         (perf_ops)
`endif
  );

  // Run length from the opcode rules: C = size[5:0]+1, L = size[8:6]+1.
  function automatic int n_of(input logic [31:0] w, input logic [8:0] s);
    int c, l;
    c = int'(s[5:0]) + 1;
    l = int'(s[8:6]) + 1;
    case (w[3:0])
      4'd1:       return l * l * c + DRAIN;
      4'd2, 4'd3: return 8 * l * c;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] mk_word(input int opc);
    logic [31:0] r;
    r = $urandom;
    return {r[31:4], 4'(opc)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_data = '0; size = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ctrl_operation, ctrl_in_data, ctrl_enable, ctrl_reset, busy, done, illegal, wr_ready, rd_valid} !== '0) begin
      bad++; $display("FAIL reset_outputs: got op=%h in=%h en=%b rst=%b busy=%b done=%b ill=%b wrr=%b rdv=%b want all 0",
                      ctrl_operation, ctrl_in_data, ctrl_enable, ctrl_reset, busy, done, illegal, wr_ready, rd_valid);
    end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    reset = 1'b0;
    step();
  endtask

  // Issue one operation from an empty, idle sequencer and follow it to IDLE.
  task automatic run_one(input logic [31:0] word, input logic [8:0] sz, input bit rnd,
                         input int lo, input int hi, input string name);
    int  n, remaining, idx, budget;
    bit  stall, exp_en;
    logic [3:0] opc;
    opc = word[3:0];
    n = n_of(word, sz);
    remaining = n; idx = 0; budget = n * 4 + 64;
    size = sz; cmd_valid = 1'b1; cmd_data = word;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s push_ready: got %b want 1", name, cmd_ready); end
    step();
    cmd_valid = 1'b0; cmd_data = $urandom;
    @(negedge clk);
    total++;
    if ({ctrl_operation, busy} !== {32'h0, 1'b1}) begin
      bad++; $display("FAIL %s pop_cycle: got op=%h busy=%b want op=0 busy=1", name, ctrl_operation, busy);
    end
    step();
    size = 9'($urandom);
    while (remaining > 0 && idx < budget) begin
      idx++;
      stall = rnd ? ($urandom_range(3) == 0) : (idx >= lo && idx <= hi);
      wr_valid = !stall; rd_ready = !stall; wr_data = $urandom;
      exp_en = (opc == 4'd1) ? 1'b1 : !stall;
      @(negedge clk);
      total++;
      if ({ctrl_operation, ctrl_enable, done, wr_ready, rd_valid, ctrl_in_data} !==
          {word, exp_en, 1'b0, opc == 4'd2, opc == 4'd3, (opc == 4'd2) ? wr_data : 32'h0}) begin
        bad++;
        if (bad < 20)
          $display("FAIL %s run_cycle%0d: got op=%h en=%b done=%b wrr=%b rdv=%b in=%h want op=%h en=%b done=0 wrr=%b rdv=%b",
                   name, idx, ctrl_operation, ctrl_enable, done, wr_ready, rd_valid, ctrl_in_data,
                   word, exp_en, opc == 4'd2, opc == 4'd3);
      end
      if (exp_en) remaining--;
      step();
    end
    total++;
    if (remaining != 0) begin bad++; $display("FAIL %s timeout: got %0d beats left want 0", name, remaining); end
    wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({ctrl_operation, done, ctrl_enable} !== {32'h0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL %s gap: got op=%h done=%b en=%b want op=0 done=1 en=1", name, ctrl_operation, done, ctrl_enable);
    end
    step();
    @(negedge clk);
    total++;
    if ({ctrl_operation, done, busy} !== {32'h0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL %s idle: got op=%h done=%b busy=%b want 0 0 0", name, ctrl_operation, done, busy);
    end
    step();
    ops_model++;
    busy_model += idx;
  endtask

  task automatic test_mult_directed();
    run_one(32'h0000_1841, 9'o101, 1'b0, 0, -1, "mult_c2l2");
  endtask

  task automatic test_write_stall();
    run_one(mk_word(2), 9'd0, 1'b0, 3, 5, "write_stall");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    logic [31:0] exp_op [$];
    bit          exp_dn [$];
    logic [31:0] eo;
    bit          ed;
    int          n;
    size = {3'($urandom_range(1)), 6'($urandom_range(3))};
    w[0] = mk_word(3);
    w[1] = mk_word(1);
    w[2] = mk_word($urandom_range(3, 1));
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = n_of(w[i], size);
      repeat (n) begin exp_op.push_back(w[i]); exp_dn.push_back(1'b0); end
      exp_op.push_back(32'h0); exp_dn.push_back(1'b1);
      busy_model += n;
      ops_model++;
    end
    exp_op.push_back(32'h0); exp_dn.push_back(1'b0);
    for (int c = 0; c < exp_op.size() + 2; c++) begin
      if (c < 3) begin cmd_valid = 1'b1; cmd_data = w[c]; end
      else cmd_valid = 1'b0;
      @(negedge clk);
      if (c >= 1) begin
        eo = (c >= 2) ? exp_op[c-2] : 32'h0;
        ed = (c >= 2) ? exp_dn[c-2] : 1'b0;
        total++;
        if ({ctrl_operation, done} !== {eo, ed}) begin
          bad++;
          if (bad < 20)
            $display("FAIL b2b cycle%0d: got op=%h done=%b want op=%h done=%b", c, ctrl_operation, done, eo, ed);
        end
      end
      step();
    end
    cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] w [3];
    logic [31:0] r;
    r = $urandom;
    w[0] = 32'h0;
    w[1] = 32'h5;
    w[2] = {r[31:4], 4'($urandom_range(15, 4))};
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin cmd_valid = 1'b1; cmd_data = w[c]; end
      else cmd_valid = 1'b0;
      @(negedge clk);
      if (c >= 1) begin
        total++;
        if ({ctrl_operation, done, illegal} !== {32'h0, 1'b0, (c >= 2 && c <= 4)}) begin
          bad++; $display("FAIL illegal cycle%0d: got op=%h done=%b ill=%b want op=0 done=0 ill=%b",
                          c, ctrl_operation, done, illegal, (c >= 2 && c <= 4));
        end
      end
      step();
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL illegal_busy: got %b want 0", busy); end
    step();
  endtask

  task automatic test_random();
    int opc;
    for (int i = 0; i < 6; i++) begin
      opc = $urandom_range(3, 1);
      run_one(mk_word(opc), {3'($urandom_range(3)), 6'($urandom)}, 1'b1, 0, -1, $sformatf("rand%0d", i));
    end
`ifdef OP_SEQUENCER_PERF_EN
    total++;
    if (perf_ops !== 32'(ops_model)) begin bad++; $display("FAIL perf_ops: got %0d want %0d", perf_ops, ops_model); end
    total++;
    if (perf_busy_cycles !== 32'(busy_model)) begin
      bad++; $display("FAIL perf_busy: got %0d want %0d", perf_busy_cycles, busy_model);
    end
`endif
  endtask

  task automatic test_flush();
    logic [31:0] first;
    first = mk_word(1);
    size = 9'o777; cmd_valid = 1'b1; cmd_data = first;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_data = mk_word($urandom_range(3, 1));
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL fill%0d_ready: got %b want 1", i, cmd_ready); end
      step();
    end
    cmd_data = mk_word(1);
    @(negedge clk);
    total++;
    if ({cmd_ready, ctrl_operation} !== {1'b0, first}) begin
      bad++; $display("FAIL full: got ready=%b op=%h want ready=0 op=%h", cmd_ready, ctrl_operation, first);
    end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({ctrl_reset, ctrl_operation, done, busy} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL flush_cycle: got rst=%b op=%h done=%b busy=%b want 1 0 0 1", ctrl_reset, ctrl_operation, done, busy);
    end
    step();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({ctrl_reset, ctrl_operation, done, busy, cmd_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
        bad++; $display("FAIL post_flush%0d: got rst=%b op=%h done=%b busy=%b rdy=%b want 0 0 0 0 1",
                        c, ctrl_reset, ctrl_operation, done, busy, cmd_ready);
      end
      step();
    end
`ifdef OP_SEQUENCER_PERF_EN
    total++;
    if ({perf_ops, perf_busy_cycles} !== 64'h0) begin
      bad++; $display("FAIL perf_flush: got ops=%0d busy=%0d want 0 0", perf_ops, perf_busy_cycles);
    end
`endif
    // A push arriving with flush must be dropped.
    flush = 1'b1; cmd_valid = 1'b1; cmd_data = mk_word(1); size = 9'd0;
    step();
    flush = 1'b0; cmd_valid = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({ctrl_operation, busy} !== {32'h0, 1'b0}) begin
        bad++; $display("FAIL flush_drop%0d: got op=%h busy=%b want op=0 busy=0", c, ctrl_operation, busy);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] w;
    w = mk_word(1);
    size = 9'o777; cmd_valid = 1'b1; cmd_data = w;
    step();
    cmd_valid = 1'b0;
    repeat (5) step();
    total++;
    if (ctrl_operation !== w) begin bad++; $display("FAIL pre_reset_run: got %h want %h", ctrl_operation, w); end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({ctrl_operation, ctrl_in_data, ctrl_enable, ctrl_reset, busy, done, illegal, wr_ready, rd_valid} !== '0) begin
      bad++; $display("FAIL async_reset: got op=%h en=%b busy=%b done=%b want all 0", ctrl_operation, ctrl_enable, busy, done);
    end
`ifdef OP_SEQUENCER_PERF_EN
    total++;
    if (perf_ops !== 32'h0) begin bad++; $display("FAIL async_reset_perf: got %0d want 0", perf_ops); end
`endif
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_write_stall();
    test_back_to_back();
    test_illegal();
    test_random();
    test_flush();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
